cymo_scheduler: RTL

CYMO_SCHEDULER -- requirements
Module: cymo_scheduler

---
 rtl/cymo_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/cymo_scheduler.sv
// Reciprocal-gate frequency scheduler: sweeps the enabled channels in turn, gating each
// for at least GATE_TIME reference cycles between signal rising edges.
module cymo_sync_lane (
   input  logic clk_fs,
   input  logic rst_n,
   input  logic sig,
   output logic rise
);
   logic s1, s2, hist;

   always_ff @(posedge clk_fs) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         hist <= 1'b0;
      end else begin
         s1   <= sig;
         s2   <= s1;
         hist <= s2;
      end
   end

   assign rise = s2 & ~hist;
endmodule

module cymo_scheduler #(
   parameter int CLK_FS    = 200_000_000,
   parameter int GATE_TIME = 100_000,
   parameter int TIMEOUT   = 400_000
) (
   input  logic        clk_fs,
   input  logic        rst_n,
   input  logic [3:0]  sig_in,
   input  logic [3:0]  ch_en,
   input  logic        start,
   input  logic        continuous,
   input  logic        stop,
   output logic        busy,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [1:0]  res_ch,
   output logic [31:0] res_fx_cnt,
   output logic [31:0] res_fs_cnt,
   output logic        res_timeout,
   output logic        sweep_done
);
   localparam int NUM_CH = 4;
   localparam int PW     = 2;
   localparam logic [31:0] GATE_T = 32'(GATE_TIME);
   localparam logic [31:0] TO_T   = 32'(TIMEOUT);
   localparam logic [31:0] CMAX   = 32'hFFFF_FFFF;

   if (CLK_FS <= 0 || GATE_TIME < 2 || TIMEOUT <= GATE_TIME) begin : g_param_err
      $error("cymo_scheduler: illegal CLK_FS/GATE_TIME/TIMEOUT");
   end

   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ARM, S_GATE, S_REPORT} state_t;

   typedef struct packed {
      logic [PW-1:0] ch;
      logic [31:0]   fx;
      logic [31:0]   fs;
      logic          to;
   } res_t;

   state_t              state_q, state_n;
   logic [NUM_CH-1:0]   rise, en_q;
   logic [PW-1:0]       ptr;
   logic [31:0]         timer, fs_cnt, fx_cnt;
   logic [31:0]         timer_inc, fs_inc, fx_upd;
   logic                abort_q, abort, rise_sel, gate_close, gate_to, arm_to;
   logic [PW:0]         lo_ch, lo_en, nxt;
   res_t                res_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      cymo_sync_lane u_lane (.clk_fs(clk_fs), .rst_n(rst_n), .sig(sig_in[i]), .rise(rise[i]));
   end

   // {found, index} of the lowest set bit of m strictly above position 'above'
   function automatic logic [PW:0] pick(input logic [NUM_CH-1:0] m, input int above);
      pick = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i] && i > above) pick = {1'b1, PW'(i)};
   endfunction

   always_comb begin
      rise_sel   = rise[ptr];
      timer_inc  = (timer == CMAX) ? timer : timer + 32'd1;
      fs_inc     = (fs_cnt == CMAX) ? fs_cnt : fs_cnt + 32'd1;
      fx_upd     = (rise_sel && fx_cnt != CMAX) ? fx_cnt + 32'd1 : fx_cnt;
      gate_close = rise_sel && (fs_inc >= GATE_T);
      gate_to    = !gate_close && (fs_inc >= TO_T);
      arm_to     = !rise_sel && (timer_inc >= TO_T);
      abort      = abort_q | stop;
      lo_ch      = pick(ch_en, -1);
      lo_en      = pick(en_q, -1);
      nxt        = pick(en_q, int'(ptr));
   end

   always_ff @(posedge clk_fs) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_n;
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:   if (!stop && start && |ch_en) state_n = S_SELECT;
         S_SELECT: state_n = stop ? S_IDLE : S_ARM;
         S_ARM: begin
            if (stop)          state_n = S_IDLE;
            else if (rise_sel) state_n = S_GATE;
            else if (arm_to)   state_n = S_REPORT;
         end
         S_GATE: begin
            if (stop)                      state_n = S_IDLE;
            else if (gate_close || gate_to) state_n = S_REPORT;
         end
         S_REPORT: begin
            // a stop seen while reporting lets the result drain, then idles
            if (res_ready) begin
               if (!abort && (nxt[PW] || continuous)) state_n = S_SELECT;
               else                                   state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_fs) begin
      if (!rst_n) begin
         en_q       <= '0;
         ptr        <= '0;
         timer      <= '0;
         fs_cnt     <= '0;
         fx_cnt     <= '0;
         abort_q    <= 1'b0;
         res_q      <= '0;
         sweep_done <= 1'b0;
      end else begin
         sweep_done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               abort_q <= 1'b0;
               if (state_n == S_SELECT) begin
                  en_q <= ch_en;
                  ptr  <= lo_ch[PW-1:0];
               end
            end
            S_SELECT: timer <= '0;
            S_ARM: begin
               timer  <= timer_inc;
               fs_cnt <= '0;
               fx_cnt <= '0;
               if (state_n == S_REPORT) res_q <= '{ch: ptr, fx: '0, fs: '0, to: 1'b1};
            end
            S_GATE: begin
               if (stop) begin
                  fs_cnt <= '0;
                  fx_cnt <= '0;
               end else begin
                  fs_cnt <= fs_inc;
                  fx_cnt <= fx_upd;
                  if (gate_close)   res_q <= '{ch: ptr, fx: fx_upd, fs: fs_inc, to: 1'b0};
                  else if (gate_to) res_q <= '{ch: ptr, fx: '0, fs: '0, to: 1'b1};
               end
            end
            S_REPORT: begin
               if (stop) abort_q <= 1'b1;
               if (res_ready) begin
                  if (!abort && nxt[PW]) begin
                     ptr <= nxt[PW-1:0];
                  end else begin
                     sweep_done <= !abort;
                     ptr        <= lo_en[PW-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign res_valid   = (state_q == S_REPORT);
   assign res_ch      = res_q.ch;
   assign res_fx_cnt  = res_q.fx;
   assign res_fs_cnt  = res_q.fs;
   assign res_timeout = res_q.to;
endmodule
